// File: rtl/in_reg_filt.sv
// Pad input register: synchronizer, stable-count glitch filter, edge detect,
// and a single-entry valid/ready edge event with a sticky overflow flag.
module in_reg_filt #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic padIn,
  input  logic sel,
  output logic dataOut,
  output logic rise,
  output logic fall,
  output logic evt_valid,
  output logic evt_type,
  input  logic evt_ready,
  output logic ovf,
  input  logic ovf_clr
);

  // Terminal count of the 4-bit stability counter; unused when the filter is off.
  localparam logic [3:0] CNT_MAX = (FILTER_LEN == 0) ? 4'd0 : 4'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;
  logic                   filt;
  logic                   filt_d;
  logic                   filt_nxt;
  logic [3:0]             cnt;
  logic [3:0]             cnt_nxt;
  logic                   filt_edge;

  assign sync_q = sync_ff[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], padIn};
    end
  end

  // NOTE: both outputs get a default before any branch, otherwise a missed
  // path would infer a latch instead of combinational logic.
  always_comb begin
    filt_nxt = filt;
    cnt_nxt  = 4'd0;
    if (FILTER_LEN == 0) begin
      filt_nxt = sync_q;
    end else if (sync_q == filt) begin
      cnt_nxt = 4'd0;
    end else if (cnt == CNT_MAX) begin
      filt_nxt = sync_q;
    end else begin
      cnt_nxt = cnt + 4'd1;
    end
  end

  assign filt_edge = (filt_nxt != filt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt   <= RESET_VAL;
      filt_d <= RESET_VAL;
      cnt    <= 4'd0;
    end else begin
      filt   <= filt_nxt;
      filt_d <= filt;
      cnt    <= cnt_nxt;
    end
  end

  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;

  // A new edge always wins the single slot; it only counts as lost data when
  // the previous event was still unaccepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_type  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (filt_edge) begin
        evt_valid <= 1'b1;
        evt_type  <= filt_nxt;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end

      if (filt_edge && evt_valid && !evt_ready) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign dataOut = sel ? padIn : filt;

endmodule

// File: tb/tb_in_reg_filt.sv
// Directed self-checking bench for in_reg_filt with default parameters
// (2 sync stages, filter length 4, reset value 0).
module tb_in_reg_filt;

  logic clk = 1'b0;
  logic rst_n;
  logic padIn;
  logic sel;
  logic dataOut;
  logic rise;
  logic fall;
  logic evt_valid;
  logic evt_type;
  logic evt_ready;
  logic ovf;
  logic ovf_clr;

  int n_checks = 0;
  int n_errors = 0;

  in_reg_filt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .padIn     (padIn),
    .sel       (sel),
    .dataOut   (dataOut),
    .rise      (rise),
    .fall      (fall),
    .evt_valid (evt_valid),
    .evt_type  (evt_type),
    .evt_ready (evt_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge only.
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_dout"},  {7'd0, dataOut},   8'd0);
    check({tag, "_rise"},  {7'd0, rise},      8'd0);
    check({tag, "_fall"},  {7'd0, fall},      8'd0);
    check({tag, "_valid"}, {7'd0, evt_valid}, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; padIn = 1'b0; sel = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
    step(2);

    // Reset state
    check("rst_dout",  {7'd0, dataOut},   8'd0);
    check("rst_valid", {7'd0, evt_valid}, 8'd0);
    check("rst_type",  {7'd0, evt_type},  8'd0);
    check("rst_ovf",   {7'd0, ovf},       8'd0);
    check("rst_rise",  {7'd0, rise},      8'd0);
    check("rst_fall",  {7'd0, fall},      8'd0);
    sel = 1'b1; padIn = 1'b1; #1;
    check("rst_bypass", {7'd0, dataOut}, 8'd1);
    sel = 1'b0; padIn = 1'b0; #1;
    rst_n = 1'b1;

    // 1: rise latency of 6 edges, single-cycle pulse
    step(1);
    padIn = 1'b1;
    step(5);
    check("t1_e5_dout",  {7'd0, dataOut},   8'd0);
    check("t1_e5_valid", {7'd0, evt_valid}, 8'd0);
    check("t1_e5_rise",  {7'd0, rise},      8'd0);
    step(1);
    check("t1_e6_dout",  {7'd0, dataOut},   8'd1);
    check("t1_e6_valid", {7'd0, evt_valid}, 8'd1);
    check("t1_e6_type",  {7'd0, evt_type},  8'd1);
    check("t1_e6_rise",  {7'd0, rise},      8'd1);
    check("t1_e6_fall",  {7'd0, fall},      8'd0);
    step(1);
    check("t1_e7_rise",  {7'd0, rise},      8'd0);
    check("t1_e7_fall",  {7'd0, fall},      8'd0);
    check("t1_e7_valid", {7'd0, evt_valid}, 8'd1);
    check("t1_e7_ovf",   {7'd0, ovf},       8'd0);
    evt_ready = 1'b1;
    step(1);
    check("t1_ack_valid", {7'd0, evt_valid}, 8'd0);
    evt_ready = 1'b0;

    // 2: 3-cycle glitch is suppressed and the counter recovers
    padIn = 1'b0;
    do_reset();
    padIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_quiet($sformatf("t2_hi%0d", i));
    end
    padIn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check_quiet($sformatf("t2_lo%0d", i));
    end
    check("t2_cnt", {4'd0, dut.cnt}, 8'd0);

    // 3: bypass follows pad with zero latency, toggles are filtered out
    sel = 1'b1;
    for (int i = 0; i < 10; i++) begin
      padIn = ~padIn; #1;
      check($sformatf("t3_byp%0d", i), {7'd0, dataOut}, {7'd0, padIn});
      step(1);
      check($sformatf("t3_valid%0d", i), {7'd0, evt_valid}, 8'd0);
    end
    sel = 1'b0; #1;
    check("t3_filt", {7'd0, dataOut}, 8'd0);

    // 4: unaccepted rise overwritten by fall -> ovf, clear, then accept
    padIn = 1'b0;
    do_reset();
    padIn = 1'b1;
    step(6);
    check("t4_rise_valid", {7'd0, evt_valid}, 8'd1);
    padIn = 1'b0;
    step(5);
    check("t4_e5_type", {7'd0, evt_type}, 8'd1);
    check("t4_e5_ovf",  {7'd0, ovf},      8'd0);
    step(1);
    check("t4_valid", {7'd0, evt_valid}, 8'd1);
    check("t4_type",  {7'd0, evt_type},  8'd0);
    check("t4_ovf",   {7'd0, ovf},       8'd1);
    check("t4_fall",  {7'd0, fall},      8'd1);
    check("t4_dout",  {7'd0, dataOut},   8'd0);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("t4_ovf_clr", {7'd0, ovf}, 8'd0);
    check("t4_hold_type", {7'd0, evt_type}, 8'd0);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("t4_ack_valid", {7'd0, evt_valid}, 8'd0);

    // 5: new edge with ready in the same cycle replaces without overflow
    padIn = 1'b1;
    step(6);
    check("t5_rise_valid", {7'd0, evt_valid}, 8'd1);
    padIn = 1'b0;
    step(5);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("t5_valid", {7'd0, evt_valid}, 8'd1);
    check("t5_type",  {7'd0, evt_type},  8'd0);
    check("t5_ovf",   {7'd0, ovf},       8'd0);
    // Overflow set and clear in the same cycle: set wins
    padIn = 1'b1;
    step(5);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("t5_setwin_ovf",  {7'd0, ovf},      8'd1);
    check("t5_setwin_type", {7'd0, evt_type}, 8'd1);

    // 6: reset mid-filter with an event pending, then full latency again
    padIn = 1'b0;
    step(4);
    check("t6_cnt_pre", {4'd0, dut.cnt}, 8'd2);
    rst_n = 1'b0; #1;
    check("t6_rst_valid", {7'd0, evt_valid}, 8'd0);
    check("t6_rst_ovf",   {7'd0, ovf},       8'd0);
    check("t6_rst_dout",  {7'd0, dataOut},   8'd0);
    check("t6_rst_cnt",   {4'd0, dut.cnt},   8'd0);
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_quiet($sformatf("t6_idle%0d", i));
    end
    padIn = 1'b1;
    step(4);
    check("t6_cnt2", {4'd0, dut.cnt}, 8'd2);
    rst_n = 1'b0; #1;
    check("t6_rst2_rise", {7'd0, rise},    8'd0);
    check("t6_rst2_dout", {7'd0, dataOut}, 8'd0);
    step(1);
    rst_n = 1'b1;
    step(5);
    check("t6_e5_rise", {7'd0, rise}, 8'd0);
    step(1);
    check("t6_e6_rise",  {7'd0, rise},      8'd1);
    check("t6_e6_valid", {7'd0, evt_valid}, 8'd1);
    check("t6_e6_ovf",   {7'd0, ovf},       8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/in_reg_filt.md
Name: in_reg_filt

Overview:
Input-side counterpart of the output register. It captures an asynchronous pad input and passes it through a synchronizer and a stable-count glitch filter, then detects rising and falling edges. Each detected edge is presented to fabric logic as a single-entry valid/ready event, and a sel input selects a combinational bypass of the pad value. The block sits between the input pad (VPR_IPAD) and user fabric logic on AP3 I/O tiles.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops (legal range 2..4).
FILTER_LEN, 4, consecutive differing cycles required before the filtered value changes (0 = filter disabled; legal range 0..15).
RESET_VAL, 0, reset value of the synchronizer chain, the filtered value and the delayed copy of the filtered value.

Ports:
clk  input  1  sampling clock; clkbuf_sink.
rst_n  input  1  asynchronous, active-low reset.
padIn  input  1  raw pad value, asynchronous to clk.
sel  input  1  1 = dataOut is padIn (combinational bypass); 0 = dataOut is the filtered value.
dataOut  output  1  data to fabric.
rise  output  1  one-cycle pulse on a filtered 0->1 transition.
fall  output  1  one-cycle pulse on a filtered 1->0 transition.
evt_valid  output  1  edge event pending.
evt_type  output  1  type of the pending event: 1 = rise, 0 = fall.
evt_ready  input  1  consumer accepts the event.
ovf  output  1  sticky flag: an edge event was lost.
ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - sync chain = RESET_VAL, filt = RESET_VAL, filt_d = RESET_VAL, cnt = 0.
  - evt_valid = 0, evt_type = 0, ovf = 0.
  - rise = fall = 0.
  - dataOut = padIn if sel = 1, otherwise RESET_VAL.
- Synchronizer: padIn shifts through SYNC_STAGES flops; sync_q is the last stage. No logic between stages.
- Filter, evaluated each rising edge of clk; counter width is 4 bits:
  - if sync_q == filt: cnt <= 0.
  - else if cnt == FILTER_LEN-1: filt <= sync_q, cnt <= 0.
  - else: cnt <= cnt + 1.
  - FILTER_LEN = 0: filt <= sync_q every cycle and cnt stays 0.
  - Any cycle with sync_q == filt restarts the count, so a glitch shorter than FILTER_LEN cycles at sync_q never changes filt.
- Latency: padIn changes and is held stable before edge 1. sync_q updates at edge SYNC_STAGES. filt updates at edge SYNC_STAGES + max(FILTER_LEN, 1).
- Edge detect:
  - filt_d <= filt every cycle.
  - rise = filt & ~filt_d; fall = ~filt & filt_d.
  - Both are high for exactly the one cycle following the edge at which filt updated.
- Event register, at the edge where filt changes:
  - evt_valid <= 1 and evt_type <= new filt value.
  - If evt_valid = 1 and evt_ready = 0 in that cycle, the old event is overwritten and ovf <= 1.
  - If evt_valid = 1 and evt_ready = 1 in that cycle, the new event replaces the old one and ovf is not set.
- Handshake:
  - With no new edge, evt_valid & evt_ready clears evt_valid at the next edge.
  - evt_type holds its value while evt_valid = 1.
  - evt_ready is ignored while evt_valid = 0.
- ovf: cleared by ovf_clr. If a set condition and ovf_clr occur in the same cycle, set wins.
- Bypass: sel affects only dataOut. The sync, filter, edge and event logic run regardless of sel.
- Reset asserted mid-filter or with an event pending discards all state immediately. After release, no edge is reported for a pad already at RESET_VAL.
- Timing annotations: padIn, sel, evt_ready and ovf_clr are SETUP to clk. rise, fall, evt_valid, evt_type and ovf are CLK_TO_Q. padIn to dataOut in bypass is the only combinational path.

Test Plan:
1. Defaults, sel = 0. padIn 0->1 held before edge 1 -> dataOut = 1 and evt_valid = 1 (evt_type = 1) after edge 6; rise = 1 for one cycle only; fall never asserts.
2. padIn high for 3 cycles, then low -> filt, dataOut, rise, fall and evt_valid stay 0; cnt returns to 0.
3. sel = 1, padIn toggled every cycle -> dataOut follows padIn with zero cycles of latency; the filter suppresses all toggles; evt_valid = 0.
4. Rise event pending, evt_ready = 0, then padIn falls -> event replaced with evt_type = 0; ovf = 1. Pulse ovf_clr -> ovf = 0. Assert evt_ready -> evt_valid = 0 at the next edge.
5. Event pending with evt_ready = 1 in the same cycle a new edge is filtered -> evt_valid stays 1 with the new type; ovf stays 0.
6. padIn = 1 held, rst_n pulsed low at cnt = 2 -> all outputs reset immediately. After release, the full latency of 6 edges elapses again before rise.
